// File: rtl/reg_checkpoint_monitor_if.sv
// -----------------------------------------------------------------------------
// reg_checkpoint_monitor_if
// Bundles the two buses that the checkpoint monitor consumes:
//   * the snooped register-file writeback port (wb_en / wb_addr / wb_data)
//   * the checkpoint-table programming port (cfg_we / cfg_idx / cfg_flag /
//     cfg_reg / cfg_expected)
// Modports:
//   master : side that drives both buses (core writeback + config host)
//   slave  : the monitor, which only observes them
// Parameters:
//   XLEN        data width of registers and checkpoint values
//   NUM_ENTRIES checkpoint table depth (sets the width of cfg_idx)
// -----------------------------------------------------------------------------
interface reg_checkpoint_monitor_if #(
  parameter int XLEN        = 32,
  parameter int NUM_ENTRIES = 16
);
  localparam int IW = (NUM_ENTRIES > 2) ? $clog2(NUM_ENTRIES) : 1;

  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic [XLEN-1:0] cfg_flag;
  logic [4:0]      cfg_reg;
  logic [XLEN-1:0] cfg_expected;

  modport master (
    output wb_en, wb_addr, wb_data,
    output cfg_we, cfg_idx, cfg_flag, cfg_reg, cfg_expected
  );

  modport slave (
    input wb_en, wb_addr, wb_data,
    input cfg_we, cfg_idx, cfg_flag, cfg_reg, cfg_expected
  );
endinterface

// File: rtl/reg_checkpoint_monitor.sv
// -----------------------------------------------------------------------------
// reg_checkpoint_monitor
// On-board self-test monitor for the Riscv151 core. It keeps a shadow copy of
// x0..x31 by snooping regfile writebacks and walks a programmable checkpoint
// table: for each entry it waits until the flag register holds the entry's
// flag value, then compares one register against the expected value.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (slave)    writeback snoop port and checkpoint-table write port
//   start          pulse: begin checking (ignored while busy)
//   num_entries    active entry count, sampled on start, saturated to depth
//   busy           checking in progress (WAIT_FLAG / CHECK)
//   done           terminal state reached (PASS / FAIL / TIMEOUT)
//   pass/fail/timeout  terminal status flags
//   cur_idx        entry being processed, or the failing entry
//   fail_got       shadow value read at the failing check
//   err_count      (optional) number of mismatching entries
//
// Optional feature, macro REG_CHECKPOINT_MONITOR_ERR_COUNT_EN:
//   When defined, mismatches are counted in err_count and checking continues
//   to the end; the run finishes in FAIL if any entry mismatched. fail_got and
//   cur_idx keep the first mismatch. When undefined, the first mismatch stops
//   the run in FAIL.
// -----------------------------------------------------------------------------
module reg_checkpoint_monitor #(
  parameter int  XLEN           = 32,
  parameter int  NUM_ENTRIES    = 16,
  parameter int  FLAG_REG       = 20,
  parameter int  TIMEOUT_CYCLES = 1000,
  localparam int IW             = (NUM_ENTRIES > 2) ? $clog2(NUM_ENTRIES) : 1,
  localparam int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  reg_checkpoint_monitor_if.slave   bus,
  input  logic                      start,
  input  logic [IW:0]               num_entries,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
`ifdef REG_CHECKPOINT_MONITOR_ERR_COUNT_EN
  output logic [IW:0]               err_count,
`endif
  output logic [IW-1:0]             cur_idx,
  output logic [XLEN-1:0]           fail_got
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FLAG = 3'd1,
    ST_CHECK     = 3'd2,
    ST_PASS      = 3'd3,
    ST_FAIL      = 3'd4,
    ST_TIMEOUT   = 3'd5
  } state_e;

  localparam logic [4:0]    FLAG_IDX    = 5'(FLAG_REG);
  localparam logic [IW:0]   MAX_ENTRIES = (IW+1)'(NUM_ENTRIES);
  localparam logic [IW:0]   ONE_ENTRY   = (IW+1)'(1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(TIMEOUT_CYCLES - 1);

  state_e                           state_r;
  logic [31:0][XLEN-1:0]            shadow_r;
  logic [NUM_ENTRIES-1:0][XLEN-1:0] tbl_flag_r;
  logic [NUM_ENTRIES-1:0][XLEN-1:0] tbl_exp_r;
  logic [NUM_ENTRIES-1:0][4:0]      tbl_reg_r;
  logic [IW-1:0]                    idx_r;
  logic [IW:0]                      num_r;
  logic [CW-1:0]                    cnt_r;

  logic            busy_state_s;
  logic            start_ok_s;
  logic            cfg_ok_s;
  logic            flag_hit_s;
  logic            chk_ok_s;
  logic            last_s;
  logic            tmo_s;
  logic [XLEN-1:0] chk_val_s;
  logic [IW:0]     num_sat_s;
  logic [IW-1:0]   idx_inc_s;

  // Qualify start/config strobes and form the flag/check comparisons.
  always_comb begin
    busy_state_s = (state_r == ST_WAIT_FLAG) || (state_r == ST_CHECK);
    start_ok_s   = start && !busy_state_s;
    cfg_ok_s     = bus.cfg_we && !busy_state_s && (int'(bus.cfg_idx) < NUM_ENTRIES);
    flag_hit_s   = (shadow_r[FLAG_IDX] == tbl_flag_r[idx_r]);
    chk_val_s    = shadow_r[tbl_reg_r[idx_r]];
    chk_ok_s     = (chk_val_s == tbl_exp_r[idx_r]);
    last_s       = ({1'b0, idx_r} == (num_r - ONE_ENTRY));
    // The counter value before the edge equals elapsed busy cycles minus one,
    // so this edge is the TIMEOUT_CYCLES-th busy cycle.
    tmo_s        = (cnt_r == CNT_LAST);
    idx_inc_s    = idx_r + IW'(1);
    if (num_entries > MAX_ENTRIES) begin
      num_sat_s = MAX_ENTRIES;
    end else begin
      num_sat_s = num_entries;
    end
  end

  // Shadow register file; x0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
    end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
      shadow_r[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Checkpoint table, writable only while no check is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_flag_r <= '0;
      tbl_exp_r  <= '0;
      tbl_reg_r  <= '0;
    end else if (cfg_ok_s) begin
      tbl_flag_r[bus.cfg_idx] <= bus.cfg_flag;
      tbl_exp_r[bus.cfg_idx]  <= bus.cfg_expected;
      tbl_reg_r[bus.cfg_idx]  <= bus.cfg_reg;
    end
  end

  // Checkpoint sequencer with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      num_r    <= '0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      cur_idx  <= '0;
      fail_got <= '0;
`ifdef REG_CHECKPOINT_MONITOR_ERR_COUNT_EN
      err_count <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          if (start_ok_s) begin
            idx_r    <= '0;
            cur_idx  <= '0;
            cnt_r    <= '0;
            fail_got <= '0;
            num_r    <= num_sat_s;
            fail     <= 1'b0;
            timeout  <= 1'b0;
`ifdef REG_CHECKPOINT_MONITOR_ERR_COUNT_EN
            err_count <= '0;
`endif
            if (num_sat_s == '0) begin
              state_r <= ST_PASS;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              state_r <= ST_WAIT_FLAG;
              busy    <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
            end
          end
        end

        ST_WAIT_FLAG: begin
          cnt_r <= cnt_r + CW'(1);
          if (tmo_s) begin
            state_r <= ST_TIMEOUT;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (flag_hit_s) begin
            state_r <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          cnt_r <= cnt_r + CW'(1);
          if (tmo_s) begin
            state_r <= ST_TIMEOUT;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
`ifdef REG_CHECKPOINT_MONITOR_ERR_COUNT_EN
            if (!chk_ok_s) begin
              err_count <= err_count + ONE_ENTRY;
              if (err_count == '0) begin
                fail_got <= chk_val_s;
              end
            end
            if (last_s) begin
              busy <= 1'b0;
              done <= 1'b1;
              if (!chk_ok_s || (err_count != '0)) begin
                state_r <= ST_FAIL;
                fail    <= 1'b1;
              end else begin
                state_r <= ST_PASS;
                pass    <= 1'b1;
              end
            end else begin
              idx_r   <= idx_inc_s;
              state_r <= ST_WAIT_FLAG;
              // cur_idx freezes on the first mismatching entry.
              if (chk_ok_s && (err_count == '0)) begin
                cur_idx <= idx_inc_s;
              end
            end
`else
            if (!chk_ok_s) begin
              state_r  <= ST_FAIL;
              busy     <= 1'b0;
              done     <= 1'b1;
              fail     <= 1'b1;
              fail_got <= chk_val_s;
            end else if (last_s) begin
              state_r <= ST_PASS;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              idx_r   <= idx_inc_s;
              cur_idx <= idx_inc_s;
              state_r <= ST_WAIT_FLAG;
            end
`endif
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
          fail    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_checkpoint_monitor.md
Name: reg_checkpoint_monitor

Overview:
Synthesizable self-test monitor for Riscv151. It snoops the register-file writeback port and keeps a shadow copy of x0..x31. It steps through a programmable table of checkpoints: wait until the flag register holds a value, then compare one register against an expected value. It reports pass, fail or timeout on status outputs, so assembly tests run on the Zynq board without a simulator.

Parameters:
XLEN, 32, data width of registers and checkpoint values
NUM_ENTRIES, 16, checkpoint table depth; IW = max(1,$clog2(NUM_ENTRIES))
FLAG_REG, 20, register index polled as the progress flag
TIMEOUT_CYCLES, 1000, cycles allowed from start to completion; CW = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wb_en  in  1  regfile write enable (snooped)
wb_addr  in  5  regfile write index
wb_data  in  XLEN  regfile write data
cfg_we  in  1  table write strobe
cfg_idx  in  IW  table entry index
cfg_flag  in  XLEN  flag value awaited by the entry
cfg_reg  in  5  register checked by the entry
cfg_expected  in  XLEN  expected register value
start  in  1  begin checking (pulse)
num_entries  in  IW+1  active entry count, sampled on start
busy  out  1  checking in progress
done  out  1  terminal state reached
pass  out  1  all entries matched
fail  out  1  mismatch detected
timeout  out  1  TIMEOUT_CYCLES elapsed before completion
cur_idx  out  IW  entry being processed / failing entry
fail_got  out  XLEN  shadow value read at the failing check

Behaviour:
- Reset: all outputs 0; shadow regs, table, idx, counter cleared; state IDLE.
- Shadow: on clk with wb_en && wb_addr!=0, shadow[wb_addr] <= wb_data. x0 always reads 0. Active in every state. Cleared only by rst_n.
- Table: cfg_we is honoured only in IDLE or a terminal state. cfg_idx >= NUM_ENTRIES is ignored.
- States: IDLE, WAIT_FLAG, CHECK, PASS, FAIL, TIMEOUT. busy=1 in WAIT_FLAG/CHECK. done=1 in PASS/FAIL/TIMEOUT. pass/fail/timeout are asserted in their respective states.
- start in IDLE or a terminal state:
  - latch num_entries; clear idx, counter, fail_got; clear done/pass/fail/timeout.
  - go to PASS if num_entries==0, else WAIT_FLAG.
  - start while busy is ignored.
- WAIT_FLAG: leave when the registered shadow[FLAG_REG]==table[idx].flag. This is a level compare, so a write becomes visible the cycle after wb_en.
- CHECK: one cycle.
  - On match: if idx==num_entries-1, go to PASS; else idx++ and go to WAIT_FLAG.
  - An already-satisfied flag is re-matched next cycle, so consecutive entries sharing a flag value cost 2 cycles each.
  - On mismatch: go to FAIL; fail_got <= shadow[table[idx].reg]; cur_idx holds idx.
- Timeout counter increments every busy cycle. When it reaches TIMEOUT_CYCLES the state goes to TIMEOUT. This has priority over any same-cycle flag match or check result.
- num_entries > NUM_ENTRIES is saturated to NUM_ENTRIES.
- Terminal states hold until start or rst_n. rst_n asserted mid-check returns to IDLE immediately (async).

Optional Feature:
Macro: REG_CHECKPOINT_MONITOR_ERR_COUNT_EN.
- With the macro:
  - adds output err_count (IW+1 bits, reset 0, cleared on start).
  - a mismatch increments err_count and continues as if matched; fail_got/cur_idx capture the first mismatch only.
  - at the end, go to FAIL if err_count!=0, else PASS.
- Without the macro: err_count is absent; the first mismatch stops in FAIL.

Test Plan:
- Program entry0 {flag=1, reg=1, exp=300} and entry1 {flag=2, reg=1, exp=500}, num_entries=2, start. Write x1=300, then x20=1, then x1=500, then x20=2 -> pass=1, done=1, fail=0, timeout=0, busy falls two cycles after the x20=2 write.
- Same table, but write x1=299 before x20=1 -> fail=1, cur_idx=0, fail_got=299; later writes leave status unchanged.
- Entries {2, x1, 500} and {2, x2, 100}, both satisfied by one x20=2 write -> pass=1 with no second flag write needed.
- TIMEOUT_CYCLES=1000, never write x20 -> timeout=1 exactly 1000 cycles after start, pass=fail=0.
- Assert rst_n mid-WAIT_FLAG, then start again -> all outputs 0 after reset, shadow x1 reads 0, pass requires the writes again; writes with wb_addr=0, data 5 leave shadow x0=0.
- With ERR_COUNT_EN: mismatch on entries 0 and 2 of 3 -> fail=1, err_count=2, cur_idx=0.
